// File: rtl/regbank_write_arbiter.sv
// Two-requester write arbiter in front of a small register bank.
// Arbitrates single-cycle writes from two requesters (round-robin on
// contention) and runs a bank-wide clear that zeroes every register.
//
// state | meaning
// IDLE  | waiting; a pending clear wins over both requesters
// GRANT | one write issued to the bank, winner acknowledged (lasts one cycle)
// CLEAR | writing zero to register `counter`, one register per cycle
module regbank_write_arbiter #(
   parameter int size_reg = 16,
   parameter int addr_reg = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_0,
   input  logic                req_1,
   input  logic [addr_reg-1:0] addr_0,
   input  logic [addr_reg-1:0] addr_1,
   input  logic [size_reg-1:0] data_0,
   input  logic [size_reg-1:0] data_1,
   output logic                ack_0,
   output logic                ack_1,
   input  logic                clear_req,
   output logic                clear_busy,
   output logic                clear_done,
   output logic                write_reg,
   output logic [addr_reg-1:0] end_write,
   output logic [size_reg-1:0] write_data
);

   typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

   localparam logic [addr_reg-1:0] last_addr = '1;
   localparam logic [addr_reg-1:0] one_addr  = addr_reg'(1);

   state_t              state, state_nx;
   logic                clear_pending, pending_nx;
   logic                pointer, pointer_nx;
   logic [addr_reg-1:0] counter, counter_nx;
   logic                write_reg_nx, ack_0_nx, ack_1_nx;
   logic                clear_busy_nx, clear_done_nx;
   logic [addr_reg-1:0] end_write_nx;
   logic [size_reg-1:0] write_data_nx;
   logic                grant_1;

   // State, bookkeeping and all outputs are registered together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         clear_pending <= 1'b0;
         pointer       <= 1'b0;
         counter       <= '0;
         write_reg     <= 1'b0;
         end_write     <= '0;
         write_data    <= '0;
         ack_0         <= 1'b0;
         ack_1         <= 1'b0;
         clear_busy    <= 1'b0;
         clear_done    <= 1'b0;
      end else begin
         state         <= state_nx;
         clear_pending <= pending_nx;
         pointer       <= pointer_nx;
         counter       <= counter_nx;
         write_reg     <= write_reg_nx;
         end_write     <= end_write_nx;
         write_data    <= write_data_nx;
         ack_0         <= ack_0_nx;
         ack_1         <= ack_1_nx;
         clear_busy    <= clear_busy_nx;
         clear_done    <= clear_done_nx;
      end
   end

   // Next-state and next-output decode; pulses default low, data holds.
   always_comb begin
      state_nx      = state;
      pending_nx    = clear_pending | clear_req;
      pointer_nx    = pointer;
      counter_nx    = counter;
      write_reg_nx  = 1'b0;
      end_write_nx  = end_write;
      write_data_nx = write_data;
      ack_0_nx      = 1'b0;
      ack_1_nx      = 1'b0;
      clear_busy_nx = clear_busy;
      clear_done_nx = 1'b0;
      grant_1       = 1'b0;
      case (state)
         IDLE: begin
            if (clear_pending) begin
               // a clear_req on this same edge counts as a new request
               state_nx      = CLEAR;
               pending_nx    = clear_req;
               counter_nx    = '0;
               write_reg_nx  = 1'b1;
               end_write_nx  = '0;
               write_data_nx = '0;
               clear_busy_nx = 1'b1;
            end else if (req_0 || req_1) begin
               grant_1      = req_1 && (!req_0 || pointer);
               state_nx     = GRANT;
               write_reg_nx = 1'b1;
               if (grant_1) begin
                  end_write_nx  = addr_1;
                  write_data_nx = data_1;
                  ack_1_nx      = 1'b1;
                  pointer_nx    = 1'b0;
               end else begin
                  end_write_nx  = addr_0;
                  write_data_nx = data_0;
                  ack_0_nx      = 1'b1;
                  pointer_nx    = 1'b1;
               end
            end
         end
         GRANT: begin
            state_nx = IDLE;
         end
         CLEAR: begin
            if (counter == last_addr) begin
               state_nx      = IDLE;
               clear_busy_nx = 1'b0;
               clear_done_nx = 1'b1;
            end else begin
               counter_nx    = counter + one_addr;
               write_reg_nx  = 1'b1;
               end_write_nx  = counter + one_addr;
               write_data_nx = '0;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter with hand-computed expectations.
module tb_regbank_write_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_0 = 1'b0, req_1 = 1'b0;
   logic [1:0]  addr_0 = '0, addr_1 = '0;
   logic [15:0] data_0 = '0, data_1 = '0;
   logic        ack_0, ack_1;
   logic        clear_req = 1'b0;
   logic        clear_busy, clear_done;
   logic        write_reg;
   logic [1:0]  end_write;
   logic [15:0] write_data;

   int checks = 0;
   int failures = 0;
   int n_wr, n_done;

   always #5 clock = ~clock;

   regbank_write_arbiter #(.size_reg(16), .addr_reg(2)) dut (
      .clock(clock), .reset(reset),
      .req_0(req_0), .req_1(req_1),
      .addr_0(addr_0), .addr_1(addr_1),
      .data_0(data_0), .data_1(data_1),
      .ack_0(ack_0), .ack_1(ack_1),
      .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
      .write_reg(write_reg), .end_write(end_write), .write_data(write_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr"},   {31'd0, write_reg},  32'd0);
      check({tag, "_addr"}, {30'd0, end_write},  32'd0);
      check({tag, "_data"}, {16'd0, write_data}, 32'd0);
      check({tag, "_acks"}, {30'd0, ack_1, ack_0}, 32'd0);
      check({tag, "_busy"}, {31'd0, clear_busy}, 32'd0);
      check({tag, "_done"}, {31'd0, clear_done}, 32'd0);
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1;
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      // asynchronous reset before any clock edge
      #1 reset = 1'b0;
      #2 check_all_zero("rst");
      @(negedge clock);
      reset = 1'b1;

      // single write from requester 0
      req_0 = 1'b1; addr_0 = 2'd2; data_0 = 16'hABCD;
      tick();
      check("single_wr",   {31'd0, write_reg},  32'd1);
      check("single_addr", {30'd0, end_write},  32'd2);
      check("single_data", {16'd0, write_data}, 32'hABCD);
      check("single_acks", {30'd0, ack_1, ack_0}, 32'd1);
      req_0 = 1'b0; addr_0 = 2'd0; data_0 = 16'h0;
      tick();
      check("single_wr_off", {31'd0, write_reg}, 32'd0);
      check("single_ack_off", {30'd0, ack_1, ack_0}, 32'd0);

      // contention from reset: grants 0,1,0,1 on cycles 1,3,5,7
      pulse_reset();
      req_0 = 1'b1; addr_0 = 2'd1; data_0 = 16'h1111;
      req_1 = 1'b1; addr_1 = 2'd3; data_1 = 16'h2222;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check("cont_both", {31'd0, ack_0 & ack_1}, 32'd0);
         if (c % 2 == 0) begin
            check("cont_idle_wr", {31'd0, write_reg}, 32'd0);
            check("cont_idle_acks", {30'd0, ack_1, ack_0}, 32'd0);
         end else if (c % 4 == 1) begin
            check("cont_g0_acks", {30'd0, ack_1, ack_0}, 32'd1);
            check("cont_g0_addr", {30'd0, end_write}, 32'd1);
            check("cont_g0_data", {16'd0, write_data}, 32'h1111);
         end else begin
            check("cont_g1_acks", {30'd0, ack_1, ack_0}, 32'd2);
            check("cont_g1_addr", {30'd0, end_write}, 32'd3);
            check("cont_g1_data", {16'd0, write_data}, 32'h2222);
         end
      end
      req_0 = 1'b0; req_1 = 1'b0;
      tick();
      check("cont_quiet", {31'd0, write_reg}, 32'd0);

      // clear from IDLE: one cycle to latch, four zero writes, done pulse
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("clr_latch_busy", {31'd0, clear_busy}, 32'd0);
      check("clr_latch_wr", {31'd0, write_reg}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("clr_wr",   {31'd0, write_reg},  32'd1);
         check("clr_addr", {30'd0, end_write},  i);
         check("clr_data", {16'd0, write_data}, 32'd0);
         check("clr_busy", {31'd0, clear_busy}, 32'd1);
         check("clr_acks", {30'd0, ack_1, ack_0}, 32'd0);
      end
      tick();
      check("clr_end_wr",   {31'd0, write_reg},  32'd0);
      check("clr_end_busy", {31'd0, clear_busy}, 32'd0);
      check("clr_end_done", {31'd0, clear_done}, 32'd1);
      tick();
      check("clr_done_once", {31'd0, clear_done}, 32'd0);

      // clear raised during a grant to requester 1; requester 0 waits
      req_1 = 1'b1; addr_1 = 2'd1; data_1 = 16'h5555;
      tick();
      check("prio_g1_acks", {30'd0, ack_1, ack_0}, 32'd2);
      check("prio_g1_data", {16'd0, write_data}, 32'h5555);
      req_1 = 1'b0; clear_req = 1'b1;
      req_0 = 1'b1; addr_0 = 2'd3; data_0 = 16'h7777;
      tick();
      clear_req = 1'b0;
      check("prio_gap_wr", {31'd0, write_reg}, 32'd0);
      check("prio_gap_acks", {30'd0, ack_1, ack_0}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("prio_clr_addr", {30'd0, end_write}, i);
         check("prio_clr_busy", {31'd0, clear_busy}, 32'd1);
         check("prio_clr_acks", {30'd0, ack_1, ack_0}, 32'd0);
      end
      tick();
      check("prio_done", {31'd0, clear_done}, 32'd1);
      check("prio_done_acks", {30'd0, ack_1, ack_0}, 32'd0);
      tick();
      check("prio_g0_acks", {30'd0, ack_1, ack_0}, 32'd1);
      check("prio_g0_addr", {30'd0, end_write}, 32'd3);
      check("prio_g0_data", {16'd0, write_data}, 32'h7777);
      req_0 = 1'b0;
      tick();

      // clear requested again mid-clear: two full sequences back to back
      n_wr = 0; n_done = 0;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      n_wr += int'(write_reg); n_done += int'(clear_done);
      tick();
      n_wr += int'(write_reg); n_done += int'(clear_done);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      n_wr += int'(write_reg); n_done += int'(clear_done);
      for (int i = 0; i < 9; i++) begin
         tick();
         n_wr += int'(write_reg); n_done += int'(clear_done);
      end
      check("dbl_writes", n_wr, 32'd8);
      check("dbl_dones", n_done, 32'd2);
      check("dbl_busy_end", {31'd0, clear_busy}, 32'd0);

      // reset while the clear is writing register 1
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      tick();
      tick();
      check("rclr_addr", {30'd0, end_write}, 32'd1);
      check("rclr_busy", {31'd0, clear_busy}, 32'd1);
      #2 reset = 1'b0;
      #1 check_all_zero("rclr_async");
      @(negedge clock);
      reset = 1'b1;
      n_wr = 0; n_done = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_wr += int'(write_reg) + int'(clear_busy) + int'(ack_0) + int'(ack_1);
         n_done += int'(clear_done);
      end
      check("rclr_no_resume", n_wr, 32'd0);
      check("rclr_no_done", n_done, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
